// File: rtl/subarashii_pkg.sv
// ---------------------------------------------------------------------------
// subarashii_pkg
// Shared definitions for the memory arbiter slice.
//   WORD_W       : memory data / address width
//   arb_state_t  : arbiter FSM states (IDLE, ACCESS, RESP)
//   OWN_*        : owner codes reported on the arbiter's owner output
// ---------------------------------------------------------------------------
package subarashii_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : clear to zero
//   i_inc      : increment by one, holding at MAX
//   o_cnt      : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W   = 4,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != W'(MAX))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port memory between instruction fetch (if_*) and data
// load/store (d_*). Data has fixed priority; a fetch that has lost MAX_WAIT
// arbitrations is force-granted. A transaction is latched at grant, drives
// memory for MEM_LAT cycles, then pulses the owner's done for one cycle.
//   clk, rst       : clock, asynchronous active-low reset
//   if_req/if_addr : fetch request; if_rdata/if_done fetch result
//   d_req/d_we/d_addr/d_wdata : data request; d_rdata/d_done data result
//   mem_*          : memory macro interface (driven only in ACCESS)
//   busy, owner    : arbiter status (owner 0 none, 1 fetch, 2 data)
// ---------------------------------------------------------------------------
module mem_arbiter
   import subarashii_pkg::*;
#(
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic [WORD_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              busy,
   output logic [1:0]        owner
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic [3:0]        r_acc_cnt;
   logic [3:0]        w_wait_cnt;
   logic [WORD_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_we;
   logic [1:0]        r_owner;
   logic [WORD_W-1:0] r_if_rdata;
   logic [WORD_W-1:0] r_d_rdata;
   logic              w_grant_if;
   logic              w_grant_d;
   logic              w_last_acc;

   // Fetch wins when alone or when it has been starved long enough.
   assign w_grant_if = (r_state == IDLE) && if_req &&
                       (!d_req || (w_wait_cnt >= 4'(MAX_WAIT)));
   assign w_grant_d  = (r_state == IDLE) && d_req && !w_grant_if;
   assign w_last_acc = (r_state == ACCESS) && (r_acc_cnt == 4'(MEM_LAT));

   // wait_cnt counts arbitrations a pending fetch loses to data.
   sat_counter #(
      .W   (4),
      .MAX (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst),
      .i_clr (w_grant_if),
      .i_inc (if_req && w_grant_d),
      .o_cnt (w_wait_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_grant_if || w_grant_d) w_next_state = ACCESS;
         ACCESS:  if (w_last_acc) w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Transaction latches, access counter and per-port read data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc_cnt  <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_owner    <= OWN_NONE;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_if) begin
                  r_addr    <= if_addr;
                  r_wdata   <= '0;
                  r_we      <= 1'b0;
                  r_owner   <= OWN_IF;
                  r_acc_cnt <= 4'd1;
               end else if (w_grant_d) begin
                  r_addr    <= d_addr;
                  r_wdata   <= d_wdata;
                  r_we      <= d_we;
                  r_owner   <= OWN_D;
                  r_acc_cnt <= 4'd1;
               end
            end
            ACCESS: begin
               if (w_last_acc) begin
                  if (!r_we) begin
                     if (r_owner == OWN_IF) r_if_rdata <= mem_rdata;
                     else                   r_d_rdata  <= mem_rdata;
                  end
               end else begin
                  r_acc_cnt <= r_acc_cnt + 4'd1;
               end
            end
            RESP: begin
               r_owner   <= OWN_NONE;
               r_acc_cnt <= '0;
            end
            default: r_owner <= OWN_NONE;
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign owner     = r_owner;
   assign if_done   = (r_state == RESP) && (r_owner == OWN_IF);
   assign d_done    = (r_state == RESP) && (r_owner == OWN_D);
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = (r_state == ACCESS);
   assign mem_we    = (r_state == ACCESS) && r_we;
   assign mem_addr  = (r_state == ACCESS) ? r_addr  : '0;
   assign mem_wdata = (r_state == ACCESS) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Scenario bench for mem_arbiter with MEM_LAT = 2, MAX_WAIT = 3. Inputs are
// driven 1 time unit after the rising edge and outputs are checked in the
// same slot, so cycle N below means "after the Nth edge since the request".
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] rd_val;
  logic        busy;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];
  logic [1:0]  own_q[$];

  mem_arbiter #(.MEM_LAT(2), .MAX_WAIT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (rd_val),
    .busy      (busy),
    .owner     (owner)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; rd_val = 16'hFFFF;
    cyc(); cyc();
    n_checks++;
    if ({busy, owner, mem_en, mem_we, if_done, d_done} !== 7'b0) begin
      $display("FAIL reset_ctrl: got %b expected 0", {busy, owner, mem_en, mem_we, if_done, d_done});
      n_errors++;
    end
    n_checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
      n_errors++;
    end
    rst = 1'b1;
  endtask

  task automatic test_lone_fetch();
    logic [15:0] exp;
    if_req = 1'b1; if_addr = 16'h0010; rd_val = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    cyc();
    if_req = 1'b0; if_addr = 16'hFFFF;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if ({mem_en, mem_we, owner, mem_addr} !== {1'b1, 1'b0, 2'd1, 16'h0010}) begin
        $display("FAIL fetch_access c%0d: en/we/own/addr=%b/%b/%0d/%h expected 1/0/1/0010", c, mem_en, mem_we, owner, mem_addr);
        n_errors++;
      end
      cyc();
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({if_done, d_done, owner, mem_en, if_rdata} !== {1'b1, 1'b0, 2'd1, 1'b0, exp}) begin
      $display("FAIL fetch_resp: ifd/dd/own/en/rdata=%b/%b/%0d/%b/%h expected 1/0/1/0/%h", if_done, d_done, owner, mem_en, if_rdata, exp);
      n_errors++;
    end
    cyc();
    n_checks++;
    if ({busy, owner, if_done} !== 4'b0) begin
      $display("FAIL fetch_idle: busy/own/done=%b/%0d/%b expected 0/0/0", busy, owner, if_done);
      n_errors++;
    end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; rd_val = 16'hDEAD;
    cyc();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 16'hFFFF;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if ({mem_en, mem_we, owner, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'd2, 16'h0200, 16'h1234}) begin
        $display("FAIL store_access c%0d: en/we/own/addr/wd=%b/%b/%0d/%h/%h expected 1/1/2/0200/1234", c, mem_en, mem_we, owner, mem_addr, mem_wdata);
        n_errors++;
      end
      cyc();
    end
    n_checks++;
    if ({d_done, if_done, d_rdata} !== {1'b1, 1'b0, 16'h0000}) begin
      $display("FAIL store_resp: dd/ifd/rdata=%b/%b/%h expected 1/0/0000", d_done, if_done, d_rdata);
      n_errors++;
    end
    cyc();
  endtask

  task automatic test_drop_load();
    logic [15:0] exp;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; rd_val = 16'h5A5A;
    exp_q.push_back(16'h5A5A);
    cyc();
    d_req = 1'b0; d_addr = 16'h0FFF;
    n_checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0300}) begin
      $display("FAIL drop_access: en/we/addr=%b/%b/%h expected 1/0/0300", mem_en, mem_we, mem_addr);
      n_errors++;
    end
    cyc(); cyc();
    exp = exp_q.pop_front();
    n_checks++;
    if ({d_done, d_rdata} !== {1'b1, exp}) begin
      $display("FAIL drop_resp: dd/rdata=%b/%h expected 1/%h", d_done, d_rdata, exp);
      n_errors++;
    end
    cyc();
    n_checks++;
    if ({busy, d_done} !== 2'b0) begin
      $display("FAIL drop_idle: busy/dd=%b/%b expected 0/0", busy, d_done);
      n_errors++;
    end
  endtask

  task automatic test_contention();
    int dones = 0;
    logic [1:0] exp_own;
    logic [1:0] got_own;
    own_q.push_back(2'd2); own_q.push_back(2'd2); own_q.push_back(2'd2);
    own_q.push_back(2'd1); own_q.push_back(2'd2);
    if_req = 1'b1; if_addr = 16'h00A0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00D0;
    rd_val = 16'h7777;
    for (int c = 0; c < 40 && dones < 5; c++) begin
      cyc();
      n_checks++;
      if (if_done && d_done) begin
        $display("FAIL both_done c%0d: if_done=1 d_done=1 expected not both", c);
        n_errors++;
      end
      if (if_done || d_done) begin
        got_own = if_done ? 2'd1 : 2'd2;
        exp_own = own_q.pop_front();
        dones++;
        n_checks++;
        if (got_own !== exp_own) begin
          $display("FAIL grant_order #%0d: got owner %0d expected %0d", dones, got_own, exp_own);
          n_errors++;
        end
        if (dones == 5) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    n_checks++;
    if (dones != 5) begin
      $display("FAIL contention_timeout: got %0d dones expected 5", dones);
      n_errors++;
      if_req = 1'b0; d_req = 1'b0;
      own_q.delete();
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_addr;
    logic        exp_done;
    logic [15:0] exp;
    for (int c = 0; c <= 12; c++) begin
      d_req  = (c < 11);
      d_we   = 1'b0;
      d_addr = 16'h0400 + 16'(c);
      rd_val = 16'h1000 + 16'(c);
      if (c % 4 == 2) exp_q.push_back(16'h1000 + 16'(c));
      if (c > 0) begin
        exp_addr = (c % 4 == 1 || c % 4 == 2) ? 16'h0400 + 16'(c - c % 4) : 16'h0000;
        exp_done = (c == 3 || c == 7 || c == 11);
        n_checks++;
        if ({mem_addr, d_done} !== {exp_addr, exp_done}) begin
          $display("FAIL b2b c%0d: addr/dd=%h/%b expected %h/%b", c, mem_addr, d_done, exp_addr, exp_done);
          n_errors++;
        end
        if (d_done) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          n_checks++;
          if (d_rdata !== exp) begin
            $display("FAIL b2b_rdata c%0d: got %h expected %h", c, d_rdata, exp);
            n_errors++;
          end
        end
      end
      cyc();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL b2b_idle: busy=%b expected 0", busy);
      n_errors++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500; rd_val = 16'h4242;
    cyc();
    d_req = 1'b0;
    cyc();
    rst = 1'b0; if_req = 1'b1; if_addr = 16'h0600;
    #1;
    n_checks++;
    if ({busy, owner, mem_en, d_done, mem_addr} !== 21'b0) begin
      $display("FAIL rst_async: busy/own/en/dd/addr=%b/%0d/%b/%b/%h expected all 0", busy, owner, mem_en, d_done, mem_addr);
      n_errors++;
    end
    cyc();
    n_checks++;
    if ({busy, owner, mem_en, mem_we, if_done, d_done, mem_addr, mem_wdata, if_rdata, d_rdata} !== 71'b0) begin
      $display("FAIL rst_hold: outputs not all 0 busy=%b own=%0d dd=%b d_rdata=%h", busy, owner, d_done, d_rdata);
      n_errors++;
    end
    rst = 1'b1;
    cyc();
    if_req = 1'b0;
    n_checks++;
    if ({owner, mem_en, mem_addr} !== {2'd1, 1'b1, 16'h0600}) begin
      $display("FAIL rst_regrant: own/en/addr=%0d/%b/%h expected 1/1/0600", owner, mem_en, mem_addr);
      n_errors++;
    end
    cyc(); cyc();
    n_checks++;
    if ({if_done, d_done, if_rdata} !== {1'b1, 1'b0, 16'h4242}) begin
      $display("FAIL rst_fetch_resp: ifd/dd/rdata=%b/%b/%h expected 1/0/4242", if_done, d_done, if_rdata);
      n_errors++;
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store();
    test_drop_load();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
